// File: rtl/chimera_wide_bypass_ctrl.sv
// Wide-port bypass mode controller: gates new AW/AR, drains in-flight writes/reads,
// then flips bypass_mode_o so the demux never reroutes with transactions outstanding.

module chimera_wide_bypass_cnt #(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc,
    input  logic                dec,
    output logic [CntWidth-1:0] cnt,
    output logic                full
);

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    assign full = (cnt == CntMax);

    // Simultaneous issue and completion cancel; an unmatched completion at zero is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CntOne;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CntOne;
        end
    end

    underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec && !inc && (cnt == '0)))
        else $error("outstanding counter decremented at zero");

endmodule

module chimera_wide_bypass_ctrl #(
    parameter int unsigned MaxOutstanding = 8,
    parameter logic        BypassResetVal = 1'b0,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                mode_req_valid_i,
    input  logic                mode_req_i,
    output logic                mode_req_ready_o,

    input  logic                slv_aw_valid_i,
    output logic                slv_aw_ready_o,
    output logic                mst_aw_valid_o,
    input  logic                mst_aw_ready_i,

    input  logic                slv_ar_valid_i,
    output logic                slv_ar_ready_o,
    output logic                mst_ar_valid_o,
    input  logic                mst_ar_ready_i,

    input  logic                b_valid_i,
    input  logic                b_ready_i,

    input  logic                r_valid_i,
    input  logic                r_ready_i,
    input  logic                r_last_i,

    output logic                bypass_mode_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] wr_outstanding_o,
    output logic [CntWidth-1:0] rd_outstanding_o
);

    localparam int unsigned NumCh = 2;  // 0: write (AW/B), 1: read (AR/R-last)

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_e;

    state_e                             state_q;
    logic                               drained;
    logic [NumCh-1:0]                   up_valid, up_ready, dn_valid, dn_ready;
    logic [NumCh-1:0]                   blk, full, inc, dec;
    logic [NumCh-1:0][CntWidth-1:0]     cnt;

    assign up_valid = {slv_ar_valid_i, slv_aw_valid_i};
    assign dn_ready = {mst_ar_ready_i, mst_aw_ready_i};
    assign dec      = {r_valid_i & r_ready_i & r_last_i, b_valid_i & b_ready_i};

    // Each channel is throttled only by its own counter; the FSM gates both.
    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        assign blk[g]      = (state_q != IDLE) | full[g];
        assign dn_valid[g] = up_valid[g] & ~blk[g];
        assign up_ready[g] = dn_ready[g] & ~blk[g];
        assign inc[g]      = dn_valid[g] & dn_ready[g];

        chimera_wide_bypass_cnt #(
            .MaxOutstanding (MaxOutstanding),
            .CntWidth       (CntWidth)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc    (inc[g]),
            .dec    (dec[g]),
            .cnt    (cnt[g]),
            .full   (full[g])
        );
    end

    assign mst_aw_valid_o   = dn_valid[0];
    assign slv_aw_ready_o   = up_ready[0];
    assign mst_ar_valid_o   = dn_valid[1];
    assign slv_ar_ready_o   = up_ready[1];
    assign wr_outstanding_o = cnt[0];
    assign rd_outstanding_o = cnt[1];

    assign drained = (cnt[0] == '0) && (cnt[1] == '0);
    assign busy_o  = (state_q != IDLE);

    // A request for the mode already in force completes without draining.
    assign mode_req_ready_o = (state_q == SWITCH) ||
                              ((state_q == IDLE) && mode_req_valid_i &&
                               (mode_req_i == bypass_mode_o));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            bypass_mode_o <= BypassResetVal;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode_req_valid_i && (mode_req_i != bypass_mode_o)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= SWITCH;
                    end
                end
                SWITCH: begin
                    bypass_mode_o <= mode_req_i;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    req_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == DRAIN) |-> mode_req_valid_i)
        else $error("mode request withdrawn while draining");

endmodule

// File: tb/tb_chimera_wide_bypass_ctrl.sv
// Directed bench: the driver queues the expected output vector for every cycle it drives,
// and a negedge monitor pops and compares against the DUT outputs.

module tb_chimera_wide_bypass_ctrl;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       mode_req_valid, mode_req, mode_req_ready;
    logic       slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
    logic       slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
    logic       b_valid, b_ready, r_valid, r_ready, r_last;
    logic       bypass_mode, busy;
    logic [3:0] wr_out, rd_out;

    always #5 clk = ~clk;

    chimera_wide_bypass_ctrl #(
        .MaxOutstanding (8),
        .BypassResetVal (1'b0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .mode_req_valid_i (mode_req_valid),
        .mode_req_i       (mode_req),
        .mode_req_ready_o (mode_req_ready),
        .slv_aw_valid_i   (slv_aw_valid),
        .slv_aw_ready_o   (slv_aw_ready),
        .mst_aw_valid_o   (mst_aw_valid),
        .mst_aw_ready_i   (mst_aw_ready),
        .slv_ar_valid_i   (slv_ar_valid),
        .slv_ar_ready_o   (slv_ar_ready),
        .mst_ar_valid_o   (mst_ar_valid),
        .mst_ar_ready_i   (mst_ar_ready),
        .b_valid_i        (b_valid),
        .b_ready_i        (b_ready),
        .r_valid_i        (r_valid),
        .r_ready_i        (r_ready),
        .r_last_i         (r_last),
        .bypass_mode_o    (bypass_mode),
        .busy_o           (busy),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out)
    );

    typedef struct {
        string      nm;
        logic [14:0] exp;
    } rec_t;

    rec_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // {ready, busy, bypass, mst_aw_valid, slv_aw_ready, mst_ar_valid, slv_ar_ready, wr, rd}
    function automatic logic [14:0] e(input logic rdy, input logic bsy, input logic byp,
                                      input logic awv, input logic awr, input logic arv,
                                      input logic arr, input int wc, input int rc);
        return {rdy, bsy, byp, awv, awr, arv, arr, 4'(wc), 4'(rc)};
    endfunction

    wire [14:0] act = {mode_req_ready, busy, bypass_mode, mst_aw_valid, slv_aw_ready,
                       mst_ar_valid, slv_ar_ready, wr_out, rd_out};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            r = q.pop_front();
            n_chk++;
            if (act !== r.exp) begin
                n_fail++;
                $display("FAIL %s: got %b, expected %b", r.nm, act, r.exp);
            end
        end
    end

    task automatic cyc(input string nm, input logic [14:0] exp);
        rec_t r;
        r.nm  = nm;
        r.exp = exp;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        mode_req_valid = 0; mode_req = 0;
        slv_aw_valid = 0; mst_aw_ready = 1;
        slv_ar_valid = 0; mst_ar_ready = 1;
        b_valid = 0; b_ready = 1;
        r_valid = 0; r_ready = 1; r_last = 0;
        @(posedge clk); #1;

        cyc("reset", e(0,0,0, 0,1,0,1, 0,0));
        rst_ni = 1'b1;

        // Request for the mode already in force completes in the same cycle
        mode_req_valid = 1; mode_req = 0;
        cyc("same_mode_ready", e(1,0,0, 0,1,0,1, 0,0));
        mode_req_valid = 0;
        cyc("idle_no_req", e(0,0,0, 0,1,0,1, 0,0));

        // 3 AWs, 2 ARs, then switch to bypass=1
        slv_aw_valid = 1; slv_ar_valid = 1;
        cyc("issue_0", e(0,0,0, 1,1,1,1, 0,0));
        cyc("issue_1", e(0,0,0, 1,1,1,1, 1,1));
        slv_ar_valid = 0;
        cyc("issue_2", e(0,0,0, 1,1,0,1, 2,2));
        slv_aw_valid = 0; mode_req_valid = 1; mode_req = 1;
        cyc("req_diff", e(0,0,0, 0,1,0,1, 3,2));
        slv_aw_valid = 1; slv_ar_valid = 1;
        cyc("drain_block", e(0,1,0, 0,0,0,0, 3,2));
        slv_aw_valid = 0; slv_ar_valid = 0; b_valid = 1;
        cyc("drain_b0", e(0,1,0, 0,0,0,0, 3,2));
        cyc("drain_b1", e(0,1,0, 0,0,0,0, 2,2));
        r_valid = 1; r_last = 1;
        cyc("drain_b2_r0", e(0,1,0, 0,0,0,0, 1,2));
        b_valid = 0; r_last = 0;
        cyc("drain_r_beat", e(0,1,0, 0,0,0,0, 0,1));
        r_last = 1;
        cyc("drain_r1", e(0,1,0, 0,0,0,0, 0,1));
        r_valid = 0; r_last = 0;
        cyc("drain_empty", e(0,1,0, 0,0,0,0, 0,0));
        cyc("switch", e(1,1,0, 0,0,0,0, 0,0));
        mode_req_valid = 0;
        cyc("mode_applied", e(0,0,1, 0,1,0,1, 0,0));

        // Fill the write counter to MaxOutstanding
        slv_aw_valid = 1;
        for (int i = 0; i < 8; i++) cyc("aw_fill", e(0,0,1, 1,1,0,1, i,0));
        slv_ar_valid = 1;
        cyc("aw_full_ar_pass", e(0,0,1, 0,0,1,1, 8,0));
        slv_ar_valid = 0; b_valid = 1;
        cyc("aw_full_b", e(0,0,1, 0,0,0,1, 8,1));
        b_valid = 0;
        cyc("aw_9th_accept", e(0,0,1, 1,1,0,1, 7,1));
        slv_aw_valid = 0;
        cyc("aw_full_again", e(0,0,1, 0,0,0,1, 8,1));

        // Drain to 4, then simultaneous AW and B
        b_valid = 1;
        cyc("b_dec_8", e(0,0,1, 0,0,0,1, 8,1));
        cyc("b_dec_7", e(0,0,1, 0,1,0,1, 7,1));
        cyc("b_dec_6", e(0,0,1, 0,1,0,1, 6,1));
        cyc("b_dec_5", e(0,0,1, 0,1,0,1, 5,1));
        slv_aw_valid = 1;
        cyc("aw_and_b", e(0,0,1, 1,1,0,1, 4,1));
        slv_aw_valid = 0; b_valid = 0; r_valid = 1; r_last = 0;
        cyc("wr_held_r_beat", e(0,0,1, 0,1,0,1, 4,1));
        r_valid = 0;
        cyc("rd_unchanged", e(0,0,1, 0,1,0,1, 4,1));

        // Reach DRAIN with wr=2, then reset
        b_valid = 1; r_valid = 1; r_last = 1;
        cyc("pre_b_r", e(0,0,1, 0,1,0,1, 4,1));
        r_valid = 0; r_last = 0;
        cyc("pre_b", e(0,0,1, 0,1,0,1, 3,0));
        b_valid = 0; mode_req_valid = 1; mode_req = 0;
        cyc("req_back", e(0,0,1, 0,1,0,1, 2,0));
        slv_aw_valid = 1;
        cyc("drain_wr2", e(0,1,1, 0,0,0,0, 2,0));
        rst_ni = 1'b0; mode_req_valid = 0;
        cyc("reset_mid_drain", e(0,0,0, 1,1,0,1, 0,0));
        rst_ni = 1'b1;
        cyc("post_reset_aw", e(0,0,0, 1,1,0,1, 0,0));
        slv_aw_valid = 0;
        cyc("post_reset_cnt", e(0,0,0, 0,1,0,1, 1,0));

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d records left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chimera_wide_bypass_ctrl.md
CHIMERA_WIDE_BYPASS_CTRL -- requirements
Module: chimera_wide_bypass_ctrl

Purpose: sequences safe switching of the cluster wide-port bypass mode (wide-to-memory-island vs. rerouted over narrow bus) by gating new AW/AR requests and draining outstanding transactions before the mode flips.

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 8, max in-flight writes and reads each (>=1).
REQ-002 SHALL have parameter BypassResetVal, default 1'b0, bypass_mode_o value after reset.
REQ-003 SHALL have derived localparam CntWidth = $clog2(MaxOutstanding+1).
REQ-004 clk_i  in  1  single clock, the SoC clock domain of the wide demux.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 mode_req_valid_i  in  1  mode change request valid.
REQ-007 mode_req_i  in  1  requested bypass mode; stable while valid and not ready.
REQ-008 mode_req_ready_o  out  1  request accepted and mode applied.
REQ-009 slv_aw_valid_i / slv_aw_ready_o  in/out  1  upstream AW handshake.
REQ-010 mst_aw_valid_o / mst_aw_ready_i  out/in  1  downstream AW handshake.
REQ-011 slv_ar_valid_i / slv_ar_ready_o, mst_ar_valid_o / mst_ar_ready_i  1 each  AR equivalent.
REQ-012 b_valid_i, b_ready_i  in  1  monitored B handshake.
REQ-013 r_valid_i, r_ready_i, r_last_i  in  1  monitored R handshake.
REQ-014 bypass_mode_o  out  1  registered mode driving the demux select override.
REQ-015 busy_o  out  1  high when FSM not IDLE.
REQ-016 wr_outstanding_o, rd_outstanding_o  out  CntWidth  current in-flight counts.

Function
REQ-017 FSM states: IDLE, DRAIN, SWITCH; state registered.
REQ-018 aw_block = (state != IDLE) | (wr_cnt == MaxOutstanding); ar_block likewise with rd_cnt.
REQ-019 mst_aw_valid_o = slv_aw_valid_i & ~aw_block; slv_aw_ready_o = mst_aw_ready_i & ~aw_block; same for AR; purely combinational, zero latency.
REQ-020 wr_cnt +1 on mst_aw_valid_o & mst_aw_ready_i; -1 on b_valid_i & b_ready_i; both in the same cycle -> unchanged.
REQ-021 rd_cnt +1 on mst AR handshake; -1 on R handshake with r_last_i; non-last beats do not change it; simultaneous -> unchanged.
REQ-022 Decrement at count 0 SHALL hold 0 and fire a simulation assertion (non-Verilator).
REQ-023 IDLE: if mode_req_valid_i and mode_req_i == bypass_mode_o -> mode_req_ready_o=1 same cycle, stay IDLE.
REQ-024 IDLE: if mode_req_valid_i and mode_req_i != bypass_mode_o -> DRAIN next cycle; handshakes in that IDLE cycle are still counted.
REQ-025 DRAIN: AW/AR blocked; when wr_cnt==0 and rd_cnt==0 (registered values) -> SWITCH next cycle; B/R continue to be accepted.
REQ-026 SWITCH: one cycle; mode_req_ready_o=1; bypass_mode_o <= mode_req_i at end of cycle; -> IDLE.
REQ-027 mode_req_ready_o SHALL be 0 in DRAIN and in IDLE without a matching request.
REQ-028 Request withdrawn in DRAIN (valid low) is a protocol violation; assertion fires, FSM continues to SWITCH using mode_req_i sampled at SWITCH.
REQ-029 Counter at MaxOutstanding blocks only its own channel; other channel unaffected.
REQ-030 W channel is not gated; W beats for an accepted AW pass untouched.

Reset
REQ-031 On rst_ni low, asynchronously: state=IDLE, wr_cnt=rd_cnt=0, bypass_mode_o=BypassResetVal, mode_req_ready_o=0, busy_o=0.
REQ-032 Reset mid-DRAIN returns to IDLE with counts cleared and mode at BypassResetVal; no pending request retained.

Verification
REQ-033 Reset, then mode_req_i=0 valid (BypassResetVal=0) -> mode_req_ready_o=1 same cycle, busy_o stays 0.
REQ-034 Issue 3 AWs, 2 ARs, then request mode=1 -> DRAIN, mst_aw/ar_valid_o=0; after 3 B and 2 R-last -> SWITCH one cycle later, ready=1, bypass_mode_o=1 next cycle.
REQ-035 MaxOutstanding=8: 8 AWs without B -> slv_aw_ready_o=0 for 9th, AR still passes; one B -> 9th AW accepted next cycle.
REQ-036 Same-cycle AW handshake and B handshake at wr_cnt=4 -> wr_cnt stays 4; R beat without r_last -> rd_cnt unchanged.
REQ-037 Assert rst_ni low during DRAIN with wr_cnt=2 -> next cycle state IDLE, counts 0, bypass_mode_o=0, blocking released.
